// File: rtl/bitplane_popcount_mac.sv
// Bit-serial dot-product accumulator. It popcounts each incoming bit-plane and then
// shift-accumulates P planes MSB-first into a signed result behind a valid/ready output register.
module bitplane_popcount_mac #(
  parameter int M          = 64,
  parameter int P          = 8,
  parameter bit SIGNED_MSB = 1'b1,
  localparam int PC_W      = $clog2(M) + 1,
  localparam int ACC_W     = $clog2(M) + P + 1,
  localparam int IDX_W     = $clog2(P)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [M-1:0]     in_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [IDX_W-1:0] plane_idx
);

  logic                    stall;
  logic [PC_W-1:0]         pc_comb;
  logic                    s1_valid;
  logic [PC_W-1:0]         s1_pc;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] pc_ext;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] acc_next;
  logic                    last_plane;
  logic                    step;
  logic                    load;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  always_comb begin
    pc_comb = '0;
    for (int i = 0; i < M; i++) begin
      pc_comb = pc_comb + PC_W'(in_bits[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_pc    <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_pc <= pc_comb;
      end
    end
  end

  // The MSB plane carries weight -2^(P-1) in two's complement.
  always_comb begin
    pc_ext     = $signed({{(ACC_W-PC_W){1'b0}}, s1_pc});
    term       = (SIGNED_MSB && (plane_idx == '0)) ? -pc_ext : pc_ext;
    acc_next   = (acc <<< 1) + term;
    last_plane = (plane_idx == IDX_W'(P - 1));
    step       = ~stall & s1_valid;
    load       = step & last_plane;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      plane_idx <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (step) begin
        if (last_plane) begin
          out_data  <= acc_next;
          acc       <= '0;
          plane_idx <= '0;
        end else begin
          acc       <= acc_next;
          plane_idx <= plane_idx + IDX_W'(1);
        end
      end
      if (load) begin
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
